// File: rtl/logic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_pipe
// Purpose  : Valid/ready bitwise-op stage with an accumulator and an output FIFO.
//            Optional macro LOGIC_PIPE_FLAGS_EN stores zero/parity flags per entry.
// Revision : 1.0 - initial release
// ============================================================================
module logic_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pi_valid,
  output logic             po_ready,
  input  logic [2:0]       pi_op,
  input  logic [WIDTH-1:0] pi_a,
  input  logic [WIDTH-1:0] pi_b,
  output logic             po_valid,
  input  logic             pi_ready,
  output logic [WIDTH-1:0] po_c,
  output logic             po_zero,
  output logic             po_parity,
  output logic [WIDTH-1:0] po_acc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef LOGIC_PIPE_FLAGS_EN
  localparam int EW = WIDTH + 2;
`else
  localparam int EW = WIDTH;
`endif

  localparam logic [2:0] c_OP_AND    = 3'b000;
  localparam logic [2:0] c_OP_OR     = 3'b001;
  localparam logic [2:0] c_OP_XOR    = 3'b010;
  localparam logic [2:0] c_OP_NAND   = 3'b011;
  localparam logic [2:0] c_OP_NOR    = 3'b100;
  localparam logic [2:0] c_OP_ANDN   = 3'b101;
  localparam logic [2:0] c_OP_ACC_OR = 3'b110;
  localparam logic [2:0] c_OP_ACC_LD = 3'b111;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_acc;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_ab;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [EW-1:0]    w_entry;
  logic [EW-1:0]    w_head;

  // Full blocks acceptance even when a pop happens in the same cycle.
  assign po_ready = (r_count != CW'(DEPTH));
  assign po_valid = (r_count != '0);
  assign w_push   = pi_valid && po_ready;
  assign w_pop    = po_valid && pi_ready;
  assign w_ab     = pi_a & pi_b;

  always_comb begin
    w_res     = '0;
    w_acc_nxt = r_acc;
    case (pi_op)
      c_OP_AND:    w_res = w_ab;
      c_OP_OR:     w_res = pi_a | pi_b;
      c_OP_XOR:    w_res = pi_a ^ pi_b;
      c_OP_NAND:   w_res = ~w_ab;
      c_OP_NOR:    w_res = ~(pi_a | pi_b);
      c_OP_ANDN:   w_res = pi_a & ~pi_b;
      c_OP_ACC_OR: begin
        w_acc_nxt = r_acc | w_ab;
        w_res     = w_acc_nxt;
      end
      c_OP_ACC_LD: begin
        w_acc_nxt = w_ab;
        w_res     = w_ab;
      end
      default:     w_res = '0;
    endcase
  end

`ifdef LOGIC_PIPE_FLAGS_EN
  assign w_entry   = {^w_res, (w_res == '0), w_res};
  assign po_zero   = po_valid & w_head[WIDTH];
  assign po_parity = po_valid & w_head[WIDTH+1];
`else
  assign w_entry   = w_res;
  assign po_zero   = 1'b0;
  assign po_parity = 1'b0;
`endif

  // Storage is never cleared, so the head is masked while empty.
  assign w_head = r_mem[r_rptr];
  assign po_c   = po_valid ? w_head[WIDTH-1:0] : '0;
  assign po_acc = r_acc;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_acc   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
        r_acc  <= w_acc_nxt;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, handshaked successor to the team's registered 8-bit AND stage. It computes one of eight bitwise operations on two WIDTH-bit operands, including two accumulate modes, and buffers results in a DEPTH-entry output FIFO. The FIFO absorbs backpressure from the consumer. The block sits between an operand source and a downstream consumer, both using valid/ready.

## Interface
Parameters:
- WIDTH, 8, operand/result width (1..64)
- DEPTH, 4, output FIFO entries (power of two, 2..16)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pi_valid  in  1  operand beat offered
- po_ready  out  1  block can accept a beat; high when FIFO count < DEPTH
- pi_op  in  3  operation select, sampled with the beat
- pi_a  in  WIDTH  operand A
- pi_b  in  WIDTH  operand B
- po_valid  out  1  FIFO head holds a result
- pi_ready  in  1  consumer accepts head
- po_c  out  WIDTH  result at FIFO head
- po_zero  out  1  head result == 0 (flag feature)
- po_parity  out  1  XOR-reduction of head result (flag feature)
- po_acc  out  WIDTH  current accumulator value

## Operation
- Input transfer: pi_valid && po_ready at a rising edge. Output transfer: po_valid && pi_ready.
- Operation encoding (r = result pushed):
  - 000: a & b
  - 001: a | b
  - 010: a ^ b
  - 011: ~(a & b)
  - 100: ~(a | b)
  - 101: a & ~b
  - 110 ACC_OR: acc <= acc | (a & b); r = new acc
  - 111 ACC_LD: acc <= a & b; r = a & b
- The accumulator changes only on accepted 110/111 beats.
- pi_op, pi_a and pi_b are don't-care when no input transfer occurs.
- FIFO:
  - Write and read pointers have log2(DEPTH) bits and wrap modulo DEPTH.
  - A count register runs 0..DEPTH.
  - Results leave in acceptance order.
- po_ready depends only on registered count; there is no combinational path from pi_ready.
  - When full, the block does not accept a beat, even if a pop occurs in the same cycle.
- Simultaneous push and pop (count 1..DEPTH-1): count unchanged, both pointers advance.
- Pop when empty is impossible, since po_valid = (count != 0).
- po_c, po_zero and po_parity come from the head entry. They hold stable while po_valid && !pi_ready.
- The result is truncated/held to WIDTH bits exactly; there is no carry.

## Timing
- Reset (async assert, synchronous release to next edge):
  - count = 0, pointers = 0, acc = 0
  - po_valid = 0, po_ready = 1
  - po_c = 0, po_zero = 0, po_parity = 0, po_acc = 0
  - FIFO storage need not be cleared, but po_c must read 0 while empty after reset.
- Latency:
  - A beat accepted at edge N is visible on po_c with po_valid = 1 after edge N when the FIFO was empty.
  - Otherwise it appears after all earlier results are popped.
- Throughput: one beat per cycle while not full and the consumer drains at one per cycle.
- Back-to-back ACC_OR beats: each beat uses the acc value updated by the previous accepted beat, with no bubble.
- po_acc is registered; it shows the new acc one edge after the accepting edge.
- Reset mid-operation discards all FIFO contents and the accumulator immediately.

## Configuration
- LOGIC_PIPE_FLAGS_EN defined:
  - FIFO entry width is WIDTH+2.
  - po_zero and po_parity are computed at push time and stored with the result.
- Not defined:
  - FIFO entry width is WIDTH.
  - po_zero and po_parity are tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then push op 000 with a=8'hF0, b=8'h3C: po_valid rises one edge later with po_c=8'h30, po_zero=0, po_parity=0. Ops 001..101 on the same operands give 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'hC0.
- ACC_LD a=8'h0F, b=8'hFF, then ACC_OR a=8'hF0, b=8'h30 back-to-back: results 8'h0F then 8'h3F; po_acc=8'h3F.
- Hold pi_ready=0 and push DEPTH=4 beats 1,2,3,4: po_ready drops after the 4th. A 5th beat offered is not accepted. Release pi_ready and the results drain 1,2,3,4 in order.
- Full FIFO, pi_valid=1 and pi_ready=1 in the same cycle: only the pop occurs, and the count becomes 3. With count=2, simultaneous push and pop keeps count=2.
- Push op 010 with a=b=8'hA5: po_c=0 and po_zero=1 with the macro defined, po_zero=0 without it. Push a=8'h01, b=8'h00 with op 001: po_parity=1 with the macro.
- Assert rst asynchronously with 3 entries and acc=8'h55 mid-cycle: po_valid=0, po_acc=0 and po_ready=1 immediately. The next push after release emerges as the sole result.
